// File: rtl/tdm_voice_scheduler_pkg.sv
// Shared definitions for the TDM voice scheduler.
// Contents: default geometry parameters, wave select encoding, scheduler FSM state encoding.
package tdm_voice_scheduler_pkg;

    localparam int unsigned D_W_DEF         = 16;
    localparam int unsigned VOICES_DEF      = 8;
    localparam int unsigned VOICES_BITS_DEF = 3;
    localparam int unsigned PHASE_W_DEF     = 24;
    localparam int unsigned LOOKUP_LAT_DEF  = 4;
    // Wavetable address is always the top byte of the phase accumulator.
    localparam int unsigned ADDR_W          = 8;

    typedef enum logic [1:0] {
        WAVE_SIN = 2'd0,
        WAVE_TRI = 2'd1,
        WAVE_SQR = 2'd2,
        WAVE_SAW = 2'd3
    } wave_e;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StIssue   = 3'd1,
        StWait    = 3'd2,
        StCapture = 3'd3,
        StDone    = 3'd4
    } state_e;

endpackage

// File: rtl/tdm_voice_scheduler_if.sv
// Wavetable lookup bus between the scheduler and the shared lookup datapath.
//   nco_addr_out     : lookup address (top byte of the voice phase)
//   wave_sel_out     : lookup wave select
//   lookup_sample_in : sample returned by the lookup datapath
// master = scheduler side, slave = lookup datapath side.
interface tdm_voice_scheduler_if #(
    parameter int unsigned D_W = 16
);
    import tdm_voice_scheduler_pkg::*;

    logic [ADDR_W-1:0] nco_addr_out;
    logic [1:0]        wave_sel_out;
    logic [D_W-1:0]    lookup_sample_in;

    modport master (
        output nco_addr_out,
        output wave_sel_out,
        input  lookup_sample_in
    );

    modport slave (
        input  nco_addr_out,
        input  wave_sel_out,
        output lookup_sample_in
    );

endinterface

// File: rtl/tdm_voice_scheduler_voice_cfg_regfile.sv
// Per-voice configuration and phase storage (voice_cfg_regfile).
// Ports:
//   clk_i, rst_ni        : clock, async active-low reset
//   cfg_*_i              : config write port (gate, wave, tune) for voice cfg_voice_i
//   ld_idx_i             : voice whose address/wave is about to be issued
//   ld_addr_o, ld_wave_o : top phase byte and wave select of ld_idx_i
//   cur_idx_i            : voice currently being captured
//   cur_gate_o           : gate of cur_idx_i
//   adv_en_i             : advance phase of cur_idx_i by its tune (only if gated)
// A config write clearing the gate forces the phase to zero and wins over a same-cycle advance.
module tdm_voice_scheduler_voice_cfg_regfile
    import tdm_voice_scheduler_pkg::*;
#(
    parameter int unsigned VOICES      = VOICES_DEF,
    parameter int unsigned VOICES_BITS = VOICES_BITS_DEF,
    parameter int unsigned PHASE_W     = PHASE_W_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cfg_we_i,
    input  logic [VOICES_BITS-1:0] cfg_voice_i,
    input  logic                   cfg_gate_i,
    input  logic [1:0]             cfg_wave_i,
    input  logic [PHASE_W-1:0]     cfg_tune_i,
    input  logic [VOICES_BITS-1:0] ld_idx_i,
    output logic [ADDR_W-1:0]      ld_addr_o,
    output logic [1:0]             ld_wave_o,
    input  logic [VOICES_BITS-1:0] cur_idx_i,
    output logic                   cur_gate_o,
    input  logic                   adv_en_i
);

    logic [VOICES-1:0]  gate_q, gate_d;
    logic [1:0]         wave_q  [VOICES];
    logic [1:0]         wave_d  [VOICES];
    logic [PHASE_W-1:0] tune_q  [VOICES];
    logic [PHASE_W-1:0] tune_d  [VOICES];
    logic [PHASE_W-1:0] phase_q [VOICES];
    logic [PHASE_W-1:0] phase_d [VOICES];

    always_comb begin
        gate_d  = gate_q;
        wave_d  = wave_q;
        tune_d  = tune_q;
        phase_d = phase_q;
        // Advance uses the pre-write tune; applied first so a clearing write overrides it.
        if (adv_en_i && gate_q[cur_idx_i]) begin
            phase_d[cur_idx_i] = phase_q[cur_idx_i] + tune_q[cur_idx_i];
        end
        if (cfg_we_i) begin
            gate_d[cfg_voice_i] = cfg_gate_i;
            wave_d[cfg_voice_i] = cfg_wave_i;
            tune_d[cfg_voice_i] = cfg_tune_i;
            if (!cfg_gate_i) begin
                phase_d[cfg_voice_i] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gate_q <= '0;
            for (int i = 0; i < VOICES; i++) begin
                wave_q[i]  <= WAVE_SIN;
                tune_q[i]  <= '0;
                phase_q[i] <= '0;
            end
        end else begin
            gate_q  <= gate_d;
            wave_q  <= wave_d;
            tune_q  <= tune_d;
            phase_q <= phase_d;
        end
    end

    assign ld_addr_o  = phase_q[ld_idx_i][PHASE_W-1 -: ADDR_W];
    assign ld_wave_o  = wave_q[ld_idx_i];
    assign cur_gate_o = gate_q[cur_idx_i];

endmodule

// File: rtl/tdm_voice_scheduler.sv
// Time-division voice scheduler and mixer.
// On sample_tick, walks voices 0..VOICES-1: issues each voice's address/wave on the lookup bus,
// waits LOOKUP_LAT cycles, captures the sample, advances the phase and accumulates the mix.
// Ports:
//   sys_clk, sys_rst_n      : clock, async active-low reset
//   sample_tick             : frame start strobe (ignored with overrun pulse while busy)
//   cfg_we/voice/gate/wave/tune : voice config write port, accepted every cycle
//   lkp (master)            : wavetable lookup bus
//   mix_out, mix_valid      : mixed frame sample and its one-cycle update pulse
//   busy, overrun           : frame in progress; tick-while-busy pulse
// Build option: MIX_SATURATE_EN clamps the sum to the D_W range; otherwise the sum is scaled
// by >>> VOICES_BITS.
module tdm_voice_scheduler
    import tdm_voice_scheduler_pkg::*;
#(
    parameter int unsigned D_W         = D_W_DEF,
    parameter int unsigned VOICES      = VOICES_DEF,
    parameter int unsigned VOICES_BITS = VOICES_BITS_DEF,
    parameter int unsigned PHASE_W     = PHASE_W_DEF,
    parameter int unsigned LOOKUP_LAT  = LOOKUP_LAT_DEF
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   sample_tick,
    input  logic                   cfg_we,
    input  logic [VOICES_BITS-1:0] cfg_voice,
    input  logic                   cfg_gate,
    input  logic [1:0]             cfg_wave,
    input  logic [PHASE_W-1:0]     cfg_tune,
    tdm_voice_scheduler_if.master  lkp,
    output logic [D_W-1:0]         mix_out,
    output logic                   mix_valid,
    output logic                   busy,
    output logic                   overrun
);

    localparam int unsigned AccW = D_W + VOICES_BITS;
    localparam int unsigned CntW = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;
    localparam logic [CntW-1:0]        CntLoad   = CntW'(LOOKUP_LAT - 1);
    localparam logic [VOICES_BITS-1:0] LastVoice = VOICES_BITS'(VOICES - 1);

    state_e                  state_q, state_d;
    logic [VOICES_BITS-1:0]  voice_q, voice_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic signed [AccW-1:0]  acc_q, acc_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [1:0]              wave_q, wave_d;
    logic [D_W-1:0]          mix_q, mix_d;
    logic                    mix_valid_q;
    logic                    overrun_q;

    logic                    load;
    logic                    adv_en;
    logic [ADDR_W-1:0]       ld_addr;
    logic [1:0]              ld_wave;
    logic                    cur_gate;
    logic signed [AccW-1:0]  sample_ext;

    tdm_voice_scheduler_voice_cfg_regfile #(
        .VOICES      (VOICES),
        .VOICES_BITS (VOICES_BITS),
        .PHASE_W     (PHASE_W)
    ) u_voice_cfg_regfile (
        .clk_i       (sys_clk),
        .rst_ni      (sys_rst_n),
        .cfg_we_i    (cfg_we),
        .cfg_voice_i (cfg_voice),
        .cfg_gate_i  (cfg_gate),
        .cfg_wave_i  (cfg_wave),
        .cfg_tune_i  (cfg_tune),
        .ld_idx_i    (voice_d),
        .ld_addr_o   (ld_addr),
        .ld_wave_o   (ld_wave),
        .cur_idx_i   (voice_q),
        .cur_gate_o  (cur_gate),
        .adv_en_i    (adv_en)
    );

    assign sample_ext = AccW'($signed(lkp.lookup_sample_in));

    always_comb begin
        state_d = state_q;
        voice_d = voice_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        load    = 1'b0;
        adv_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sample_tick) begin
                    voice_d = '0;
                    acc_d   = '0;
                    load    = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = CntLoad;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StCapture: begin
                adv_en = 1'b1;
                if (cur_gate) begin
                    acc_d = acc_q + sample_ext;
                end
                if (voice_q == LastVoice) begin
                    state_d = StDone;
                end else begin
                    voice_d = voice_q + VOICES_BITS'(1);
                    load    = 1'b1;
                    state_d = StIssue;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Address/wave are latched on entry to ISSUE so they stay frozen through CAPTURE even if
    // the voice is rewritten mid-lookup.
    always_comb begin
        addr_d = addr_q;
        wave_d = wave_q;
        if (load) begin
            addr_d = ld_addr;
            wave_d = ld_wave;
        end
    end

`ifdef MIX_SATURATE_EN
    logic acc_fits;
    assign acc_fits = (acc_q[AccW-1:D_W-1] == {(VOICES_BITS + 1){acc_q[AccW-1]}});

    always_comb begin
        mix_d = acc_q[D_W-1:0];
        if (!acc_fits) begin
            mix_d = acc_q[AccW-1] ? {1'b1, {(D_W - 1){1'b0}}} : {1'b0, {(D_W - 1){1'b1}}};
        end
    end
`else
    always_comb begin
        mix_d = D_W'(acc_q >>> VOICES_BITS);
    end
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StIdle;
            voice_q     <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            addr_q      <= '0;
            wave_q      <= WAVE_SIN;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            voice_q     <= voice_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            addr_q      <= addr_d;
            wave_q      <= wave_d;
            mix_valid_q <= (state_q == StDone);
            overrun_q   <= sample_tick && (state_q != StIdle);
            if (state_q == StDone) begin
                mix_q <= mix_d;
            end
        end
    end

    assign lkp.nco_addr_out = addr_q;
    assign lkp.wave_sel_out = wave_q;
    assign mix_out          = mix_q;
    assign mix_valid        = mix_valid_q;
    assign overrun          = overrun_q;
    assign busy             = (state_q != StIdle);

endmodule

// File: tb/tb_tdm_voice_scheduler.sv
// Bench for tdm_voice_scheduler: frame-level behavioural model plus directed literal checks.
module tb_tdm_voice_scheduler;
    import tdm_voice_scheduler_pkg::*;

    localparam int unsigned LAT       = 4;
    localparam int unsigned SLOT      = LAT + 2;
    localparam int unsigned FRAME_LEN = 8 * SLOT + 1;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        sample_tick;
    logic        cfg_we;
    logic [2:0]  cfg_voice;
    logic        cfg_gate;
    logic [1:0]  cfg_wave;
    logic [23:0] cfg_tune;
    logic [15:0] mix_out;
    logic        mix_valid;
    logic        busy;
    logic        overrun;

    int n_cmp = 0;
    int n_err = 0;

    // Lookup datapath stand-in: constant or an address/wave dependent pattern.
    bit          lk_mode  = 1'b0;
    logic [15:0] lk_const = 16'h0000;
    logic [15:0] lk_pipe [LAT];

    tdm_voice_scheduler_if #(.D_W(16)) lkp ();

    tdm_voice_scheduler dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .sample_tick (sample_tick),
        .cfg_we      (cfg_we),
        .cfg_voice   (cfg_voice),
        .cfg_gate    (cfg_gate),
        .cfg_wave    (cfg_wave),
        .cfg_tune    (cfg_tune),
        .lkp         (lkp),
        .mix_out     (mix_out),
        .mix_valid   (mix_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [15:0] lkp_fn(input logic [7:0] a, input logic [1:0] w);
        if (!lk_mode) return lk_const;
        return {w, a, 6'h05};
    endfunction

    always @(posedge sys_clk) begin
        lk_pipe[0] <= lkp_fn(lkp.nco_addr_out, lkp.wave_sel_out);
        for (int i = 1; i < LAT; i++) lk_pipe[i] <= lk_pipe[i-1];
    end
    assign lkp.lookup_sample_in = lk_pipe[LAT-1];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] mix_of(input int acc);
`ifdef MIX_SATURATE_EN
        if (acc > 32767) return 16'h7FFF;
        if (acc < -32768) return 16'h8000;
        return 16'(acc);
`else
        return 16'(acc >>> 3);
`endif
    endfunction

    // ---------------- behavioural model ----------------
    bit          m_gate  [8];
    logic [1:0]  m_wave  [8];
    logic [23:0] m_tune  [8];
    logic [23:0] m_phase [8];
    logic [7:0]  m_addr  [8];
    logic [1:0]  m_wsel  [8];
    bit          m_busy;
    int          m_e;
    int          m_acc;
    logic [15:0] m_mix;
    bit          m_mv;
    bit          m_ovr;

    task automatic m_load(input int v);
        m_addr[v] = m_phase[v][23:16];
        m_wsel[v] = m_wave[v];
    endtask

    initial begin : model_cmp
        forever begin
            @(posedge sys_clk);
            if (!sys_rst_n) begin
                for (int v = 0; v < 8; v++) begin
                    m_gate[v] = 1'b0; m_wave[v] = 2'd0; m_tune[v] = '0; m_phase[v] = '0;
                    m_addr[v] = '0; m_wsel[v] = '0;
                end
                m_busy = 1'b0; m_e = 0; m_acc = 0; m_mix = '0; m_mv = 1'b0; m_ovr = 1'b0;
            end else begin
                m_ovr = sample_tick && m_busy;
                m_mv  = 1'b0;
                if (m_busy) begin
                    m_e++;
                    if (m_e % SLOT == 0 && m_e >= SLOT && m_e <= 8 * SLOT) begin
                        int v;
                        v = m_e / SLOT - 1;
                        if (m_gate[v]) begin
                            m_acc += int'($signed(lkp_fn(m_addr[v], m_wsel[v])));
                            m_phase[v] = m_phase[v] + m_tune[v];
                        end
                        if (v < 7) m_load(v + 1);
                    end
                    if (m_e == FRAME_LEN) begin
                        m_busy = 1'b0;
                        m_mv   = 1'b1;
                        m_mix  = mix_of(m_acc);
                    end
                end else if (sample_tick) begin
                    m_busy = 1'b1; m_e = 0; m_acc = 0;
                    m_load(0);
                end
                if (cfg_we) begin
                    m_gate[cfg_voice] = cfg_gate;
                    m_wave[cfg_voice] = cfg_wave;
                    m_tune[cfg_voice] = cfg_tune;
                    if (!cfg_gate) m_phase[cfg_voice] = '0;
                end
            end
            @(negedge sys_clk);
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("mix_valid", {31'd0, mix_valid}, {31'd0, m_mv});
            check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
            check("mix_out", {16'd0, mix_out}, {16'd0, m_mix});
            if (m_busy && m_e < 8 * SLOT) begin
                check("nco_addr", {24'd0, lkp.nco_addr_out}, {24'd0, m_addr[m_e / SLOT]});
                check("wave_sel", {30'd0, lkp.wave_sel_out}, {30'd0, m_wsel[m_e / SLOT]});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_edges(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic cfg_write(input int v, input bit g, input logic [1:0] w, input logic [23:0] t);
        @(negedge sys_clk);
        cfg_we = 1'b1; cfg_voice = 3'(v); cfg_gate = g; cfg_wave = w; cfg_tune = t;
        @(negedge sys_clk);
        cfg_we = 1'b0;
    endtask

    // Returns at the negedge following the tick edge.
    task automatic start_frame();
        @(negedge sys_clk);
        sample_tick = 1'b1;
        @(negedge sys_clk);
        sample_tick = 1'b0;
    endtask

    task automatic wait_mix(output int lat, output logic [15:0] mix);
        lat = 0;
        mix = '0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge sys_clk);
            if (mix_valid) begin
                lat = i;
                mix = mix_out;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        wait_edges(2);
        sys_rst_n = 1'b1;
    endtask

    int          lat;
    int          pulses;
    logic [15:0] mix;

    initial begin : stim
        sys_rst_n = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0;
        cfg_voice = '0; cfg_gate = 1'b0; cfg_wave = '0; cfg_tune = '0;
        #1 sys_rst_n = 1'b0;
        wait_edges(3);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mix_valid", {31'd0, mix_valid}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_mix_out", {16'd0, mix_out}, 32'd0);
        check("rst_addr", {24'd0, lkp.nco_addr_out}, 32'd0);
        check("rst_wave", {30'd0, lkp.wave_sel_out}, 32'd0);
        sys_rst_n = 1'b1;

        // Unconfigured frame: silence, 49-cycle latency.
        start_frame();
        check("t1_busy_e0", {31'd0, busy}, 32'd1);
        wait_mix(lat, mix);
        check("t1_latency", lat, 49);
        check("t1_mix", {16'd0, mix}, 32'h0000);
        check("t1_idle", {31'd0, busy}, 32'd0);

        // Single voice.
        lk_const = 16'h1000;
        cfg_write(0, 1'b1, WAVE_SIN, 24'h010000);
        start_frame();
        wait_mix(lat, mix);
        check("t2_latency", lat, 49);
`ifdef MIX_SATURATE_EN
        check("t2_mix", {16'd0, mix}, 32'h1000);
`else
        check("t2_mix", {16'd0, mix}, 32'h0200);
`endif
        start_frame();
        check("t2_addr_v0", {24'd0, lkp.nco_addr_out}, 32'h01);
        wait_mix(lat, mix);

        // All voices, full-scale extremes.
        for (int v = 1; v < 8; v++) cfg_write(v, 1'b1, 2'(v), 24'(v * 24'h001234));
        lk_const = 16'h7FFF;
        start_frame();
        wait_mix(lat, mix);
        check("t3_mix_max", {16'd0, mix}, 32'h7FFF);
        lk_const = 16'h8000;
        start_frame();
        wait_mix(lat, mix);
        check("t3_mix_min", {16'd0, mix}, 32'h8000);

        // Tick while busy mid-frame.
        lk_const = 16'h0100;
        start_frame();
        wait_edges(9);
        sample_tick = 1'b1;
        @(negedge sys_clk);
        sample_tick = 1'b0;
        check("t4_overrun", {31'd0, overrun}, 32'd1);
        wait_mix(lat, mix);
        check("t4_latency", lat, 39);
`ifdef MIX_SATURATE_EN
        check("t4_mix", {16'd0, mix}, 32'h0800);
`else
        check("t4_mix", {16'd0, mix}, 32'h0100);
`endif
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (mix_valid) pulses++;
        end
        check("t4_extra_pulses", pulses, 0);

        // Tick during DONE is an overrun; tick one cycle later starts a frame.
        start_frame();
        wait_edges(48);
        check("t4b_busy_done", {31'd0, busy}, 32'd1);
        sample_tick = 1'b1;
        @(negedge sys_clk);
        check("t4b_overrun", {31'd0, overrun}, 32'd1);
        check("t4b_valid", {31'd0, mix_valid}, 32'd1);
        check("t4b_busy_fall", {31'd0, busy}, 32'd0);
        @(negedge sys_clk);
        sample_tick = 1'b0;
        check("t4b_restart", {31'd0, busy}, 32'd1);
        check("t4b_no_ovr", {31'd0, overrun}, 32'd0);
        wait_mix(lat, mix);
        check("t4b_latency", lat, 49);

        // Pattern lookup, phase wrap and gate clear during capture.
        apply_reset();
        lk_mode = 1'b1;
        cfg_write(0, 1'b1, WAVE_TRI, 24'h123456);
        cfg_write(3, 1'b1, WAVE_SAW, 24'hFFFFFF);
        cfg_write(5, 1'b1, WAVE_SQR, 24'h0A0000);
        start_frame();
        wait_mix(lat, mix);
`ifdef MIX_SATURATE_EN
        check("t5_f1_mix", {16'd0, mix}, 32'h800F);
`else
        check("t5_f1_mix", {16'd0, mix}, 32'hF001);
`endif
        start_frame();
        wait_edges(19);
        check("t5_f2_addr3", {24'd0, lkp.nco_addr_out}, 32'hFF);
        check("t5_f2_wave3", {30'd0, lkp.wave_sel_out}, 32'd3);
        wait_mix(lat, mix);
        start_frame();
        wait_edges(19);
        check("t5_f3_addr3_wrap", {24'd0, lkp.nco_addr_out}, 32'hFF);
        wait_edges(4);
        cfg_we = 1'b1; cfg_voice = 3'd3; cfg_gate = 1'b0; cfg_wave = WAVE_SIN;
        cfg_tune = 24'hFFFFFF;
        @(negedge sys_clk);
        cfg_we = 1'b0;
        wait_mix(lat, mix);
        start_frame();
        wait_edges(19);
        check("t5_f4_addr3_clr", {24'd0, lkp.nco_addr_out}, 32'h00);
        check("t5_f4_wave3", {30'd0, lkp.wave_sel_out}, 32'd0);
        wait_mix(lat, mix);
`ifdef MIX_SATURATE_EN
        check("t5_f4_mix", {16'd0, mix}, 32'hD50A);
`else
        check("t5_f4_mix", {16'd0, mix}, 32'hFAA1);
`endif

        // Reset in the middle of a frame.
        start_frame();
        wait_edges(20);
        #2 sys_rst_n = 1'b0;
        #1;
        check("t6_busy_now", {31'd0, busy}, 32'd0);
        check("t6_valid_now", {31'd0, mix_valid}, 32'd0);
        wait_edges(3);
        check("t6_mix_rst", {16'd0, mix_out}, 32'd0);
        sys_rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if (mix_valid) pulses++;
        end
        check("t6_no_valid", pulses, 0);
        start_frame();
        wait_mix(lat, mix);
        check("t6_latency", lat, 49);
        check("t6_mix", {16'd0, mix}, 32'h0000);

        wait_edges(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "bench timeout");
    end

endmodule
